// File: rtl/iq_window_accumulator.sv
`default_nettype none
// ============================================================================
// iq_window_accumulator : trigger-started I/Q window integrator, optional skip.
// Optional IQ_ACC_SAT_EN: saturating accumulators. Rev 1.0
// ============================================================================
module iq_window_accumulator #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trig,
  input  logic [CNT_WIDTH-1:0]   skip_len,
  input  logic [CNT_WIDTH-1:0]   acc_len,
  input  logic                   adc_valid,
  input  logic [IN_WIDTH-1:0]    adc_i,
  input  logic [IN_WIDTH-1:0]    adc_q,
  output logic [2*ACC_WIDTH-1:0] accumulated_output,
  output logic                   stb_start,
  output logic                   busy,
  output logic                   trig_overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SKIP  = 2'd1;
  localparam logic [1:0] S_ACCUM = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, skip_q, len_q;
  logic [ACC_WIDTH-1:0]   i_acc_q, q_acc_q;
  logic [2*ACC_WIDTH-1:0] out_q;
  logic                   stb_q, ovr_q;
  logic [CNT_WIDTH-1:0]   w_cnt_inc;
  logic                   w_start, w_skip_step, w_acc_step, w_done;

  assign w_cnt_inc = cnt_q + 1'b1;

  function automatic logic [ACC_WIDTH-1:0] f_acc_add(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [IN_WIDTH-1:0]  s);
`ifdef IQ_ACC_SAT_EN
    logic [ACC_WIDTH:0] sum;
    sum = {a[ACC_WIDTH-1], a} + {{(ACC_WIDTH+1-IN_WIDTH){s[IN_WIDTH-1]}}, s};
    // Disagreeing top two bits mean the true sum left the ACC_WIDTH range.
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])
      return sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    return sum[ACC_WIDTH-1:0];
`else
    return a + {{(ACC_WIDTH-IN_WIDTH){s[IN_WIDTH-1]}}, s};
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (trig && acc_len != '0) state_d = (skip_len != '0) ? S_SKIP : S_ACCUM;
      S_SKIP:  if (adc_valid && w_cnt_inc == skip_q) state_d = S_ACCUM;
      S_ACCUM: if (adc_valid && w_cnt_inc == len_q) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_start     = (state_q == S_IDLE) && trig && (acc_len != '0);
    w_skip_step = (state_q == S_SKIP) && adc_valid;
    w_acc_step  = (state_q == S_ACCUM) && adc_valid;
    w_done      = (state_q == S_DONE);
    busy        = (state_q != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      skip_q  <= '0;
      len_q   <= '0;
      i_acc_q <= '0;
      q_acc_q <= '0;
      out_q   <= '0;
      stb_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (w_start) begin
        skip_q  <= skip_len;
        len_q   <= acc_len;
        cnt_q   <= '0;
        i_acc_q <= '0;
        q_acc_q <= '0;
      end
      if (w_skip_step) cnt_q <= (w_cnt_inc == skip_q) ? '0 : w_cnt_inc;
      if (w_acc_step) begin
        i_acc_q <= f_acc_add(i_acc_q, adc_i);
        q_acc_q <= f_acc_add(q_acc_q, adc_q);
        cnt_q   <= w_cnt_inc;
      end
      stb_q <= w_done;
      if (w_done) out_q <= {q_acc_q, i_acc_q};
      if (trig && state_q != S_IDLE) ovr_q <= 1'b1;
    end
  end

  assign accumulated_output = out_q;
  assign stb_start          = stb_q;
  assign trig_overrun       = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_iq_window_accumulator.sv
`default_nettype none
// Bench for iq_window_accumulator: a default 32-bit instance and an 18-bit
// accumulator instance share one stimulus; windows are checked against sums of the sample list.
module tb_iq_window_accumulator;

  typedef logic signed [63:0] v_t;

  typedef struct {
    int skip; int acc; int i0; int di; int q0; int dq; int ei; int eq;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, trig, adc_valid;
  logic [15:0] skip_len, acc_len, adc_i, adc_q;
  logic [63:0] out32;
  logic [35:0] out18;
  logic        stb32, stb18, busy32, busy18, ovr32, ovr18;

  int n_cmp = 0;
  int n_bad = 0;
  int si[$];
  int sq[$];
  int gap_mode = -1;
  vec_t tbl[4];

  always #5 clk = ~clk;

  iq_window_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(32), .CNT_WIDTH(16)) dut32 (
    .clk(clk), .rst(rst), .trig(trig), .skip_len(skip_len), .acc_len(acc_len),
    .adc_valid(adc_valid), .adc_i(adc_i), .adc_q(adc_q),
    .accumulated_output(out32), .stb_start(stb32), .busy(busy32), .trig_overrun(ovr32));

  iq_window_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(18), .CNT_WIDTH(16)) dut18 (
    .clk(clk), .rst(rst), .trig(trig), .skip_len(skip_len), .acc_len(acc_len),
    .adc_valid(adc_valid), .adc_i(adc_i), .adc_q(adc_q),
    .accumulated_output(out18), .stb_start(stb18), .busy(busy18), .trig_overrun(ovr18));

  task automatic chk(input string nm, input v_t act, input v_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic v_t i32(); return v_t'($signed(out32[31:0]));  endfunction
  function automatic v_t q32(); return v_t'($signed(out32[63:32])); endfunction
  function automatic v_t i18(); return v_t'($signed(out18[17:0]));  endfunction
  function automatic v_t q18(); return v_t'($signed(out18[35:18])); endfunction

  // Accumulator arithmetic as signed integers of width w.
  function automatic longint madd(input longint a, input longint s, input int w);
    longint r, mx, mn, m;
    r  = a + s;
    m  = longint'(1) << w;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -mx - 1;
`ifdef IQ_ACC_SAT_EN
    if (r > mx) r = mx;
    if (r < mn) r = mn;
`else
    r = ((r % m) + m) % m;
    if (r > mx) r = r - m;
`endif
    return r;
  endfunction

  function automatic v_t wsum(input bit use_q, input int skip, input int acc, input int w);
    longint r = 0;
    for (int k = skip; k < skip + acc; k++) r = madd(r, use_q ? sq[k] : si[k], w);
    return v_t'(r);
  endfunction

  // Starts at a negedge, ends at the negedge where the result strobe is high.
  task automatic drive_window(input int skip, input int acc, input int ovr_at);
    int g;
    trig = 1'b1; skip_len = 16'(skip); acc_len = 16'(acc);
    @(negedge clk);
    trig = 1'b0;
    chk("stb_low_after_trig", v_t'(stb32), 0);
    chk("busy_after_trig", v_t'(busy32), 1);
    for (int k = 0; k < skip + acc; k++) begin
      adc_valid = 1'b1; adc_i = 16'(si[k]); adc_q = 16'(sq[k]);
      trig = (k == ovr_at);
      if (trig) begin acc_len = 16'd1; skip_len = 16'd0; end
      @(negedge clk);
      trig = 1'b0; adc_valid = 1'b0;
      g = (gap_mode < 0) ? int'($urandom_range(0, 2)) : gap_mode;
      if (k < skip + acc - 1) repeat (g) @(negedge clk);
    end
    // DONE cycle: a valid sample here must be dropped.
    adc_valid = 1'b1; adc_i = 16'h7abc; adc_q = 16'h8123;
    chk("stb_not_early", v_t'(stb32), 0);
    @(negedge clk);
    adc_valid = 1'b0;
    chk("stb_latency", v_t'(stb32), 1);
    chk("stb18_latency", v_t'(stb18), 1);
    chk("i_sum32", i32(), wsum(0, skip, acc, 32));
    chk("q_sum32", q32(), wsum(1, skip, acc, 32));
    chk("i_sum18", i18(), wsum(0, skip, acc, 18));
    chk("q_sum18", q18(), wsum(1, skip, acc, 18));
  endtask

  task automatic finish_idle();
    @(negedge clk);
    chk("stb_one_cycle", v_t'(stb32), 0);
    chk("busy_after_done", v_t'(busy32), 0);
  endtask

  task automatic fill(input int skip, input int acc, input int i0, input int di,
                      input int q0, input int dq);
    si.delete(); sq.delete();
    for (int k = 0; k < skip; k++) begin si.push_back(1234); sq.push_back(-1234); end
    for (int k = 0; k < acc; k++) begin si.push_back(i0 + k * di); sq.push_back(q0 + k * dq); end
  endtask

  initial begin
    int seen;
    v_t held;
    tbl[0] = '{skip: 0, acc: 4,  i0: 1,      di: 1, q0: -1,    dq: -1,  ei: 10,     eq: -10};
    tbl[1] = '{skip: 3, acc: 1,  i0: -32768, di: 0, q0: 32767, dq: 0,   ei: -32768, eq: 32767};
    tbl[2] = '{skip: 0, acc: 10, i0: -5,     di: 1, q0: 100,   dq: -20, ei: -5,     eq: 100};
    tbl[3] = '{skip: 5, acc: 3,  i0: 7,      di: 7, q0: 0,     dq: -1,  ei: 42,     eq: -3};

    rst = 1'b1; trig = 1'b0; adc_valid = 1'b0; skip_len = '0; acc_len = '0;
    adc_i = '0; adc_q = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    chk("reset_out", v_t'(out32), 0);
    chk("reset_stb", v_t'(stb32), 0);
    chk("reset_busy", v_t'(busy32), 0);
    chk("reset_ovr", v_t'(ovr32), 0);

    gap_mode = 0;
    for (int t = 0; t < 4; t++) begin
      gap_mode = t % 3;
      fill(tbl[t].skip, tbl[t].acc, tbl[t].i0, tbl[t].di, tbl[t].q0, tbl[t].dq);
      drive_window(tbl[t].skip, tbl[t].acc, -1);
      chk("tbl_i", i32(), v_t'(tbl[t].ei));
      chk("tbl_q", q32(), v_t'(tbl[t].eq));
      finish_idle();
    end

    // Skip with a gap after every sample.
    gap_mode = 1;
    si = '{100, 100, 5, 6, 7}; sq = '{-100, -100, 1, 2, -9};
    drive_window(2, 3, -1);
    chk("skipgap_i", i32(), 18);
    chk("skipgap_q", q32(), -6);
    finish_idle();

    // Overrun during ACCUM, then a zero-length trigger.
    gap_mode = 0;
    fill(1, 4, 3, -2, 9, 4);
    drive_window(1, 4, 3);
    chk("ovr_set", v_t'(ovr32), 1);
    finish_idle();
    held = v_t'(out32);
    trig = 1'b1; acc_len = 16'd0; skip_len = 16'd2;
    @(negedge clk);
    trig = 1'b0;
    chk("zero_len_busy", v_t'(busy32), 0);
    seen = 0;
    repeat (6) begin
      adc_valid = 1'b1; adc_i = 16'd50;
      @(negedge clk);
      if (stb32 || busy32) seen++;
    end
    adc_valid = 1'b0;
    chk("zero_len_no_stb", v_t'(seen), 0);
    chk("zero_len_held", v_t'(out32), held);
    chk("ovr_sticky", v_t'(ovr32), 1);

    // Reset in the middle of a window.
    trig = 1'b1; skip_len = 16'd0; acc_len = 16'd5;
    @(negedge clk);
    trig = 1'b0;
    repeat (2) begin adc_valid = 1'b1; adc_i = 16'd700; adc_q = 16'd300; @(negedge clk); end
    adc_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (4) begin @(negedge clk); if (stb32) seen++; end
    chk("rst_no_stb", v_t'(seen), 0);
    chk("rst_out", v_t'(out32), 0);
    chk("rst_busy", v_t'(busy32), 0);
    chk("rst_ovr", v_t'(ovr32), 0);
    fill(0, 3, 11, 1, -4, 0);
    drive_window(0, 3, -1);
    chk("post_rst_i", i32(), 36);
    finish_idle();

    // Back-to-back: second trigger on the strobe cycle.
    fill(2, 2, 20, 5, -7, 1);
    drive_window(2, 2, -1);
    fill(0, 3, -1, -1, 1000, 1000);
    drive_window(0, 3, -1);
    chk("b2b_i", i32(), -6);
    chk("b2b_q", q32(), 6000);
    finish_idle();
    chk("b2b_no_ovr", v_t'(ovr32), 0);

    // Overflow of the 18-bit instance.
    fill(0, 5, 32767, 0, 0, 0);
    drive_window(0, 5, -1);
`ifdef IQ_ACC_SAT_EN
    chk("ovf18_i", i18(), 131071);
`else
    chk("ovf18_i", i18(), -98309);
`endif
    chk("ovf32_i", i32(), 163835);
    finish_idle();

    // Longest window at full-scale samples.
    fill(0, 65535, 32767, 0, -32768, 0);
    drive_window(0, 65535, -1);
    chk("long_i", i32(), 2147385345);
    chk("long_q", q32(), -2147450880);
    finish_idle();

    // Randomised windows.
    gap_mode = -1;
    for (int r = 0; r < 30; r++) begin
      int sk, ac;
      sk = int'($urandom_range(0, 4));
      ac = int'($urandom_range(1, 8));
      si.delete(); sq.delete();
      for (int k = 0; k < sk + ac; k++) begin
        si.push_back(int'($signed(16'($urandom))));
        sq.push_back(int'($signed(16'($urandom))));
      end
      drive_window(sk, ac, -1);
      finish_idle();
    end
    chk("final_ovr", v_t'(ovr32), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
